// File: rtl/toggle_bank.sv
// toggle_bank: multi-channel programmable toggler.
// A start request latches a channel mask, a period and a toggle count. The
// masked outputs then invert every period cycles for the requested number of
// events, followed by a single-cycle done pulse.
module toggle_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready,
  input  logic [CHANNELS-1:0] mask,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    toggles,
  output logic [CHANNELS-1:0] out,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [CHANNELS-1:0] mask_l;
  logic [CNT_W-1:0]    per_l;
  logic [CNT_W-1:0]    timer;
  logic [CNT_W-1:0]    remain;
  logic                armed;
  logic                start;
  logic                tick;
  logic [CNT_W-1:0]    per_eff;

  // A zero period behaves like one, so the first toggle is never skipped.
  assign per_eff = (period == '0) ? CNT_W'(1) : period;

  // start is only honoured in IDLE, so ready is ignored during RUN and DONE.
  assign start = (state == IDLE) && ready && armed;
  assign tick  = (state == RUN) && (timer == '0);

  // State register; reset returns to IDLE and aborts any run without done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic: a zero-length run goes straight to DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (toggles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (tick && (remain == CNT_W'(1))) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Arming: a low ready re-arms, an accepted start consumes the arm.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (start) begin
      armed <= 1'b0;
    end else if (!ready) begin
      armed <= 1'b1;
    end
  end

  // Run datapath: latch parameters on start, count down, toggle on expiry.
  always_ff @(posedge clock) begin
    if (reset) begin
      out    <= '0;
      mask_l <= '0;
      per_l  <= '0;
      timer  <= '0;
      remain <= '0;
    end else if (start) begin
      mask_l <= mask;
      per_l  <= per_eff;
      timer  <= per_eff - CNT_W'(1);
      remain <= toggles;
    end else if (state == RUN) begin
      if (timer != '0) begin
        timer <= timer - CNT_W'(1);
      end else begin
        out    <= out ^ mask_l;
        remain <= remain - CNT_W'(1);
        timer  <= per_l - CNT_W'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/toggle_bank.md
# toggle_bank

Multi-channel, parametrised successor to the single-output toggle block. On a `ready` request it latches a channel mask, a toggle period and a toggle count. It then inverts the masked outputs every `period` cycles for `toggles` events and pulses `done` for one cycle. The block sits between a controller issuing `ready` requests and logic that consumes the per-channel toggle waveforms and the completion pulse.

## Interface
- `CHANNELS`, default 4: number of output channels.
- `CNT_W`, default 8: width of the period, count and internal counters.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ready`  in  1  start request, level-sampled, re-armed by a low level.
- `mask`  in  CHANNELS  channels that toggle in this run; latched at start.
- `period`  in  CNT_W  cycles between toggle events; 0 is treated as 1; latched at start.
- `toggles`  in  CNT_W  number of toggle events in the run; latched at start.
- `out`  out  CHANNELS  toggle outputs, registered; hold their value between runs.
- `busy`  out  1  high while a run is in progress (state RUN).
- `done`  out  1  one-cycle completion pulse (state DONE).

## Operation
- Internal state: FSM {IDLE, RUN, DONE}, `mask_l`, `per_l` (effective period), `timer`, `remain`, `armed`.
- `armed`
  - Set at any edge where `ready`=0.
  - Cleared at an edge where a start is accepted.
  - Reset value is 0, so `ready` must be seen low once after reset before the first start.
- IDLE
  - Start condition: `ready`=1 and `armed`=1 at an edge.
  - On start, latch `mask_l`=`mask`, `per_l`=max(`period`,1), `timer`=`per_l`-1, `remain`=`toggles`.
  - If `toggles`=0, go to DONE; otherwise go to RUN.
- RUN
  - If `timer`≠0: `timer` decrements.
  - If `timer`=0: `out` ^= `mask_l`, `remain` decrements, `timer` reloads to `per_l`-1.
  - If `timer`=0 and `remain`=1, go to DONE on the same edge.
- DONE: one cycle only, then IDLE unconditionally; `ready` is not sampled for a start in this state.
- `ready`, `mask`, `period` and `toggles` are ignored during RUN and DONE, except that `ready`=0 still sets `armed`.
- Outputs are decoded from the state: `busy`=(state==RUN), `done`=(state==DONE).
- `out` changes only on toggle edges or reset. `mask_l`=0 gives a valid run in which `out` never changes.
- Counters use CNT_W-bit arithmetic. `per_l`=2^CNT_W-1 and `toggles`=2^CNT_W-1 must work without overflow.

## Timing
- Reset, effective at the edge: `out`=0, `busy`=0, `done`=0, state IDLE, `armed`=0, counters 0.
- Reset mid-run aborts immediately; no `done` pulse is issued.
- Start accepted at edge T, with P=`per_l` and N=`toggles`≥1:
  - `busy`=1 from after T.
  - Toggle k (1..N) occurs at edge T+k·P.
  - At edge T+N·P: last toggle, `busy`→0, `done`→1.
  - At edge T+N·P+1: `done`→0.
- N=0: `done`=1 for the cycle after T; `busy` stays 0; `out` is unchanged.
- Earliest restart is edge T+N·P+2 (first IDLE edge), provided `ready` was low at some edge after T.
- Holding `ready` high continuously yields exactly one run.
- Latency from start to first toggle is P cycles; there is no combinational path from any input to any output.

## Test plan
- Reset with `ready`=1 held through and after reset -> `out`=0000, `busy`=0, `done`=0; no run starts until `ready` goes 0 then 1.
- `mask`=0101, `period`=3, `toggles`=4, start at T -> `out`=0101 at T+3, 0000 at T+6, 0101 at T+9, 0000 at T+12; `busy` high T+1..T+12; `done` high exactly T+12..T+13.
- `mask`=1111, `period`=0, `toggles`=3 -> `out` = 1111, 0000, 1111 at T+1, T+2, T+3; `done` after T+3; final `out`=1111 is held in IDLE.
- `toggles`=0 -> single `done` cycle after T, `busy` never high, `out` unchanged. Then `ready` held high -> no second run; drop `ready` for 1 cycle and raise it -> new run starts.
- During a run, change `mask`/`period` and pulse `ready` low then high -> waveform is unaffected; a new run starts at the first IDLE edge (T+N·P+2) with the new inputs.
- `reset` asserted at T+5 of the `period`=3, `toggles`=4 run -> `out`=0000, `busy`=0 after that edge; no `done` pulse; IDLE with `armed`=0.
